fetch_pc_sequencer: RTL and testbench
=====================================

# fetch_pc_sequencer

Fetch-stage next-PC sequencer for the 5-wide superscalar front end. It holds the fetch-group PC and produces the five slot PCs and `base_valid_i` consumed by `jump_controller_super`. From that block's jump/JALR decisions it computes the next fetch PC, masks slots after the first taken control transfer, and hands the group to decode with a valid/ready handshake. It also parks fetch on an unpredicted JALR and accepts backend redirects.

## Interface

Parameters
- `size`, 32: address/instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded at reset; word aligned.

Ports
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. One clock domain.
- `imem_valid_i` in 1: instructions for `pc_q` are present this cycle.
- `instruction_0..4` in size: fetched words (immediates only).
- `jump_0..4` in 1: from jump controller; JAL or predicted-taken branch.
- `jalr_0..4` in 1: from jump controller; slot is JALR.
- `jalr_prediction_valid` in 1: JALR target predictor hit.
- `jalr_prediction_target` in size: predicted JALR target.
- `redirect_valid_i` in 1: backend redirect (mispredict or exception).
- `redirect_pc_i` in size: redirect target.
- `fetch_ready_i` in 1: decode accepts the group.
- `current_pc_0..4` out size: `pc_q + 4*i`, to jump controller and decode.
- `base_valid_o` out 1: to jump controller `base_valid_i`.
- `fetch_valid_o` out 1: group valid to decode.
- `slot_valid_o` out 5: per-slot valid.
- `pred_taken_o` out 5: one-hot taken slot, or zero.
- `pred_target_o` out size: predicted target of the taken slot; 0 if none.

## Operation

- State machine states: `RUN` and `WAIT_JALR`. Reset state is `RUN`.
- `base_valid_o = (state==RUN) & imem_valid_i & ~redirect_valid_i`.
- `fetch_valid_o = base_valid_o`.
- Taken slot k is the lowest index with `jump_k | jalr_k`.
- `slot_valid_o[i] = fetch_valid_o & (i <= k)`. With no taken slot, all five slots are valid.
- Target for slot k:
  - `jump_k` with opcode 1101111: `pc_k + sext(J-imm)`.
  - `jump_k` with opcode 1100011: `pc_k + sext(B-imm)`.
  - `jalr_k` with `jalr_prediction_valid`: `jalr_prediction_target`.
- Unpredicted JALR (`jalr_k & ~jalr_prediction_valid`):
  - Slots 0..k delivered; `pred_taken_o` is zero for that slot.
  - On accept, state goes to `WAIT_JALR` and `pc_q` holds.
- `WAIT_JALR`: `fetch_valid_o = 0`. Leaves only on `redirect_valid_i`.
- Accept is `fetch_valid_o & fetch_ready_i`. On accept, `pc_q` becomes:
  - the target, if a slot is taken;
  - otherwise `pc_q + 20`.
- No accept: `pc_q` holds and the outputs stay stable while `imem_valid_i` holds. Decode may stall indefinitely.
- Redirect has top priority in any state. On `redirect_valid_i`:
  - `pc_q <= {redirect_pc_i[size-1:2], 2'b00}`;
  - state goes to `RUN`;
  - `fetch_valid_o` is forced 0 that cycle, so the same-cycle group is discarded.
- Arithmetic is modulo 2^size. PC wrap from 32'hFFFF_FFEC + 20 gives 0. Slot PCs wrap the same way. Target bits [1:0] are forced to 0.

## Timing

- Reset values:
  - `pc_q = RESET_PC`, state `RUN`;
  - `fetch_valid_o = base_valid_o = 0` (until `imem_valid_i`);
  - `slot_valid_o = pred_taken_o = 0`, `pred_target_o = 0`;
  - `current_pc_i = RESET_PC + 4i`.
- Decision path is combinational from `jump_*` / `jalr_*` in the same cycle. Next PC is visible on `current_pc_0` one cycle after accept.
- A redirect asserted in cycle t gives `current_pc_0 = redirect_pc` in t+1. Fetch can be valid in t+1 if `imem_valid_i`.
- Reset asserted mid-stall or in `WAIT_JALR` returns to reset values immediately, asynchronously.
- Simultaneous redirect and accept: redirect wins and the group is not delivered.

## Structure

- Package `fetch_pkg`:
  - `fetch_state_t` enum (`RUN`, `WAIT_JALR`);
  - `FETCH_WIDTH=5`, `INST_BYTES=4`;
  - opcode constants `OPC_JAL=7'b1101111`, `OPC_BRANCH=7'b1100011`, `OPC_JALR=7'b1100111`.
- Sub-module `fetch_imm_decode`: J/B immediate extraction plus sign extension, instantiated per slot. A priority encoder selects slot k.

## Test plan

- Reset, then `imem_valid_i=1`, no jumps, `fetch_ready_i=1`: PC sequence 0, 0x14, 0x28; `slot_valid_o=5'b11111`.
- Slot 2 is JAL imm=+0x100 at `pc_q=0x40`: `slot_valid_o=5'b00111`, `pred_taken_o=5'b00100`, `pred_target_o=0x148`, next `current_pc_0=0x148`.
- Slot 1 is JALR, `jalr_prediction_valid=0`: accept, then `fetch_valid_o=0` held 10 cycles; `redirect_pc_i=0x2002` gives `current_pc_0=0x2000` next cycle, state `RUN`.
- Taken branch with `fetch_ready_i=0` for 3 cycles: outputs stable and `pc_q` held; PC updates one cycle after ready.
- `redirect_valid_i` with accept at `pc_q=0x80`, target 0x400: group dropped (`fetch_valid_o=0`), next PC 0x400.
- `pc_q=0xFFFF_FFEC`, no jumps: `current_pc_4=0xFFFF_FFFC`, next PC 0x0.

Source files
------------

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

    // Sequencer states. WAIT_JALR parks fetch until the backend redirects.
    typedef enum logic [0:0] {
        RUN       = 1'b0,
        WAIT_JALR = 1'b1
    } fetch_state_t;

    // Fetch group geometry.
    localparam int FETCH_WIDTH = 5;
    localparam int INST_BYTES  = 4;

    // Opcodes that carry a PC-relative immediate or an indirect target.
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Fetch-to-decode group handshake: valid/ready plus per-slot qualifiers.
interface fetch_pc_sequencer_if
    import fetch_pkg::*;
#(
    parameter int size = 32
);
    logic                   fetch_valid_o;
    logic                   fetch_ready_i;
    logic [FETCH_WIDTH-1:0] slot_valid_o;
    logic [FETCH_WIDTH-1:0] pred_taken_o;
    logic [size-1:0]        pred_target_o;

    // Fetch side drives the group, decode side answers with ready.
    modport master (
        output fetch_valid_o,
        output slot_valid_o,
        output pred_taken_o,
        output pred_target_o,
        input  fetch_ready_i
    );

    modport slave (
        input  fetch_valid_o,
        input  slot_valid_o,
        input  pred_taken_o,
        input  pred_target_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/fetch_pc_sequencer_imm_decode.sv
// Per-slot immediate decoder: sign-extended J-type or B-type offset.
module fetch_imm_decode
    import fetch_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [size-1:0] instr_i,
    output logic [size-1:0] imm_o
);
    logic [6:0]      opcode;
    logic [size-1:0] j_imm;
    logic [size-1:0] b_imm;

    assign opcode = instr_i[6:0];

    // Immediate bit 0 is implicit zero in both formats.
    assign j_imm = {{(size-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
    assign b_imm = {{(size-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};

    // Branches use the B offset; JAL (the only other PC-relative jump) uses J.
    assign imm_o = (opcode == OPC_BRANCH) ? b_imm : j_imm;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage next-PC sequencer for the 5-wide front end. Holds the group
// PC, picks the first taken control transfer, masks later slots, and parks
// on an unpredicted JALR until the backend redirects.
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter int              size     = 32,
    parameter logic [size-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            imem_valid_i,
    input  logic [size-1:0] instruction_0,
    input  logic [size-1:0] instruction_1,
    input  logic [size-1:0] instruction_2,
    input  logic [size-1:0] instruction_3,
    input  logic [size-1:0] instruction_4,
    input  logic            jump_0,
    input  logic            jump_1,
    input  logic            jump_2,
    input  logic            jump_3,
    input  logic            jump_4,
    input  logic            jalr_0,
    input  logic            jalr_1,
    input  logic            jalr_2,
    input  logic            jalr_3,
    input  logic            jalr_4,
    input  logic            jalr_prediction_valid,
    input  logic [size-1:0] jalr_prediction_target,
    input  logic            redirect_valid_i,
    input  logic [size-1:0] redirect_pc_i,

    output logic [size-1:0] current_pc_0,
    output logic [size-1:0] current_pc_1,
    output logic [size-1:0] current_pc_2,
    output logic [size-1:0] current_pc_3,
    output logic [size-1:0] current_pc_4,
    output logic            base_valid_o,

    fetch_pc_sequencer_if.master dec_if
);
    localparam logic [0:0]      ST_RUN       = RUN;
    localparam logic [0:0]      ST_WAIT_JALR = WAIT_JALR;
    localparam logic [size-1:0] ALIGN_MASK   = {{(size-2){1'b1}}, 2'b00};
    localparam logic [size-1:0] GROUP_BYTES  = size'(FETCH_WIDTH * INST_BYTES);

    logic [size-1:0] pc_q, pc_d;
    logic [0:0]      state_q, state_d;

    logic [size-1:0] inst     [FETCH_WIDTH];
    logic [size-1:0] pc_slot  [FETCH_WIDTH];
    logic [size-1:0] imm      [FETCH_WIDTH];
    logic [size-1:0] jump_tgt [FETCH_WIDTH];

    logic [FETCH_WIDTH-1:0] jmp, jlr, ctl, keep, first_ctl;
    logic                   any_ctl, sel_jump, taken, unpred;
    logic                   base_valid, accept;
    logic [size-1:0]        sel_target, target_aligned;

    assign inst[0] = instruction_0;
    assign inst[1] = instruction_1;
    assign inst[2] = instruction_2;
    assign inst[3] = instruction_3;
    assign inst[4] = instruction_4;

    assign jmp = {jump_4, jump_3, jump_2, jump_1, jump_0};
    assign jlr = {jalr_4, jalr_3, jalr_2, jalr_1, jalr_0};
    assign ctl = jmp | jlr;

    // Slot PCs and PC-relative jump targets, one decoder per slot.
    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
        assign pc_slot[g] = pc_q + size'(INST_BYTES * g);

        fetch_imm_decode #(.size(size)) u_imm (
            .instr_i (inst[g]),
            .imm_o   (imm[g])
        );

        assign jump_tgt[g] = pc_slot[g] + imm[g];
    end

    assign current_pc_0 = pc_slot[0];
    assign current_pc_1 = pc_slot[1];
    assign current_pc_2 = pc_slot[2];
    assign current_pc_3 = pc_slot[3];
    assign current_pc_4 = pc_slot[4];

    // Priority mask: a slot survives if no earlier slot transfers control.
    always_comb begin : p_prio
        logic seen;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        seen = 1'b0;
        keep = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            keep[i] = ~seen;
            seen    = seen | ctl[i];
        end
    end

    assign first_ctl = ctl & keep;
    assign any_ctl   = |ctl;

    // Target of the first control-transfer slot; a JAL/branch wins over JALR.
    always_comb begin
        sel_jump   = 1'b0;
        sel_target = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (first_ctl[i]) begin
                sel_jump   = jmp[i];
                sel_target = jmp[i] ? jump_tgt[i] : jalr_prediction_target;
            end
        end
    end

    assign taken          = any_ctl & (sel_jump | jalr_prediction_valid);
    assign unpred         = any_ctl & ~taken;
    assign target_aligned = sel_target & ALIGN_MASK;

    // A redirect discards the same-cycle group; parked fetch never presents one.
    assign base_valid = (state_q == ST_RUN) & imem_valid_i & ~redirect_valid_i;
    assign accept     = base_valid & dec_if.fetch_ready_i;

    assign base_valid_o         = base_valid;
    assign dec_if.fetch_valid_o = base_valid;
    assign dec_if.slot_valid_o  = base_valid ? keep : '0;
    assign dec_if.pred_taken_o  = (base_valid & taken) ? first_ctl : '0;
    assign dec_if.pred_target_o = (base_valid & taken) ? target_aligned : '0;

    // Next PC and state: redirect first, then accepted group, else hold.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i & ALIGN_MASK;
            state_d = ST_RUN;
        end else if (accept) begin
            if (taken) begin
                pc_d = target_aligned;
            end else if (unpred) begin
                state_d = ST_WAIT_JALR;
            end else begin
                pc_d = pc_q + GROUP_BYTES;
            end
        end
    end

    // PC and state registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed scenarios followed by
// randomized groups, all checked against a slot-level behavioural model.
module tb_fetch_pc_sequencer;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem;
    logic [31:0] instr [5];
    logic        jmp   [5];
    logic        jlr   [5];
    logic [31:0] off   [5];
    logic        jp_valid;
    logic [31:0] jp_target;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] cpc   [5];
    logic        base_valid;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: group PC and whether fetch is parked on a JALR.
    logic [31:0] m_pc;
    bit          m_parked;

    // Model outputs for the current cycle.
    logic        e_fv;
    logic [4:0]  e_slot, e_taken;
    logic [31:0] e_target, n_pc;
    bit          n_parked;

    always #5 clk = ~clk;

    fetch_pc_sequencer_if #(.size(32)) dec_if ();

    fetch_pc_sequencer #(.size(32), .RESET_PC(RESET_PC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .imem_valid_i           (imem),
        .instruction_0          (instr[0]),
        .instruction_1          (instr[1]),
        .instruction_2          (instr[2]),
        .instruction_3          (instr[3]),
        .instruction_4          (instr[4]),
        .jump_0                 (jmp[0]),
        .jump_1                 (jmp[1]),
        .jump_2                 (jmp[2]),
        .jump_3                 (jmp[3]),
        .jump_4                 (jmp[4]),
        .jalr_0                 (jlr[0]),
        .jalr_1                 (jlr[1]),
        .jalr_2                 (jlr[2]),
        .jalr_3                 (jlr[3]),
        .jalr_4                 (jlr[4]),
        .jalr_prediction_valid  (jp_valid),
        .jalr_prediction_target (jp_target),
        .redirect_valid_i       (redir),
        .redirect_pc_i          (redir_pc),
        .current_pc_0           (cpc[0]),
        .current_pc_1           (cpc[1]),
        .current_pc_2           (cpc[2]),
        .current_pc_3           (cpc[3]),
        .current_pc_4           (cpc[4]),
        .base_valid_o           (base_valid),
        .dec_if                 (dec_if.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction encoders built from the architectural immediate layouts.
    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, OPC_JAL};
    endfunction

    function automatic logic [31:0] enc_br(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd3, 5'd2, 3'b001, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    task automatic clear_ctl();
        for (int i = 0; i < 5; i++) begin
            jmp[i]   = 1'b0;
            jlr[i]   = 1'b0;
            off[i]   = 32'h0;
            instr[i] = {$urandom_range(32'h01FF_FFFF, 0), 7'b0110011};
        end
    endtask

    task automatic put_jal(input int s, input logic [20:0] imm);
        instr[s] = enc_jal(imm);
        jmp[s]   = 1'b1;
        off[s]   = {{11{imm[20]}}, imm};
    endtask

    task automatic put_br(input int s, input logic [12:0] imm);
        instr[s] = enc_br(imm);
        jmp[s]   = 1'b1;
        off[s]   = {{19{imm[12]}}, imm};
    endtask

    task automatic put_jalr(input int s);
        instr[s] = {$urandom_range(32'h01FF_FFFF, 0), OPC_JALR};
        jlr[s]   = 1'b1;
    endtask

    // Slot-level model: find the first control transfer, derive the outputs
    // and the next PC directly from the fetch rules.
    task automatic model_eval();
        int          k;
        bit          tk;
        logic [31:0] tgt;
        k   = 5;
        tk  = 0;
        tgt = 32'h0;
        for (int i = 4; i >= 0; i--)
            if (jmp[i] || jlr[i]) k = i;
        e_fv     = !m_parked && imem && !redir;
        e_slot   = 5'b0;
        e_taken  = 5'b0;
        e_target = 32'h0;
        if (k < 5) begin
            tk  = jmp[k] || jp_valid;
            tgt = jmp[k] ? (m_pc + 32'(4 * k) + off[k]) : jp_target;
            tgt[1:0] = 2'b00;
        end
        if (e_fv) begin
            for (int i = 0; i < 5; i++)
                if (i <= k) e_slot[i] = 1'b1;
            if (tk) begin
                e_taken[k] = 1'b1;
                e_target   = tgt;
            end
        end
        n_pc     = m_pc;
        n_parked = m_parked;
        if (redir) begin
            n_pc     = {redir_pc[31:2], 2'b00};
            n_parked = 0;
        end else if (e_fv && dec_if.fetch_ready_i) begin
            if (tk)          n_pc = tgt;
            else if (k < 5)  n_parked = 1;
            else             n_pc = m_pc + 32'd20;
        end
    endtask

    // One clock: settle, compare every output with the model, clock, advance.
    task automatic cycle();
        #1;
        model_eval();
        check("base_valid",  32'(base_valid),           32'(e_fv));
        check("fetch_valid", 32'(dec_if.fetch_valid_o), 32'(e_fv));
        check("slot_valid",  32'(dec_if.slot_valid_o),  32'(e_slot));
        check("pred_taken",  32'(dec_if.pred_taken_o),  32'(e_taken));
        check("pred_target", dec_if.pred_target_o,      e_target);
        for (int i = 0; i < 5; i++)
            check($sformatf("current_pc_%0d", i), cpc[i], m_pc + 32'(4 * i));
        @(posedge clk);
        if (reset) begin
            m_pc     = n_pc;
            m_parked = n_parked;
        end
        @(negedge clk);
    endtask

    logic [31:0] saved_pc, saved_tgt, saved_slot, saved_taken;

    initial begin
        reset = 1'b0;
        imem = 1'b0;
        dec_if.fetch_ready_i = 1'b0;
        redir = 1'b0;
        redir_pc = 32'h0;
        jp_valid = 1'b0;
        jp_target = 32'h0;
        clear_ctl();
        m_pc = RESET_PC;
        m_parked = 0;

        // Reset values while held in reset.
        @(negedge clk);
        #1;
        check("rst_pc0",        cpc[0], RESET_PC);
        check("rst_pc4",        cpc[4], RESET_PC + 32'd16);
        check("rst_fetch_valid", 32'(dec_if.fetch_valid_o), 32'd0);
        check("rst_slot_valid", 32'(dec_if.slot_valid_o), 32'd0);
        check("rst_pred_taken", 32'(dec_if.pred_taken_o), 32'd0);
        check("rst_pred_target", dec_if.pred_target_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle();

        // Sequential fetch with no control transfers.
        imem = 1'b1;
        dec_if.fetch_ready_i = 1'b1;
        #1;
        check("seq_pc_a", cpc[0], 32'h0);
        check("seq_slots", 32'(dec_if.slot_valid_o), 32'h1F);
        cycle();
        check("seq_pc_b", cpc[0], 32'h14);
        cycle();
        check("seq_pc_c", cpc[0], 32'h28);
        cycle();

        // JAL in slot 2 at pc 0x40.
        redir = 1'b1;
        redir_pc = 32'h40;
        cycle();
        redir = 1'b0;
        check("jal_start_pc", cpc[0], 32'h40);
        put_jal(2, 21'h100);
        #1;
        check("jal_slots",  32'(dec_if.slot_valid_o), 32'h07);
        check("jal_taken",  32'(dec_if.pred_taken_o), 32'h04);
        check("jal_target", dec_if.pred_target_o, 32'h148);
        cycle();
        check("jal_next_pc", cpc[0], 32'h148);
        clear_ctl();

        // Unpredicted JALR in slot 1: park, then leave on redirect.
        put_jalr(1);
        jp_valid = 1'b0;
        #1;
        check("jalr_slots", 32'(dec_if.slot_valid_o), 32'h03);
        check("jalr_taken", 32'(dec_if.pred_taken_o), 32'h00);
        cycle();
        clear_ctl();
        for (int i = 0; i < 10; i++) begin
            #1;
            check("park_fetch_valid", 32'(dec_if.fetch_valid_o), 32'd0);
            cycle();
        end
        redir = 1'b1;
        redir_pc = 32'h2002;
        cycle();
        redir = 1'b0;
        check("unpark_pc", cpc[0], 32'h2000);
        #1;
        check("unpark_valid", 32'(dec_if.fetch_valid_o), 32'd1);
        cycle();

        // Taken branch held by decode back-pressure for three cycles.
        put_br(3, 13'h1FE0);
        dec_if.fetch_ready_i = 1'b0;
        #1;
        saved_pc    = cpc[0];
        saved_tgt   = dec_if.pred_target_o;
        saved_slot  = 32'(dec_if.slot_valid_o);
        saved_taken = 32'(dec_if.pred_taken_o);
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1;
            check("stall_pc",     cpc[0], saved_pc);
            check("stall_target", dec_if.pred_target_o, saved_tgt);
            check("stall_slots",  32'(dec_if.slot_valid_o), saved_slot);
            check("stall_taken",  32'(dec_if.pred_taken_o), saved_taken);
        end
        dec_if.fetch_ready_i = 1'b1;
        cycle();
        check("stall_release_pc", cpc[0], saved_pc + 32'hC - 32'h20);
        clear_ctl();

        // Redirect colliding with an accept at 0x80.
        redir = 1'b1;
        redir_pc = 32'h80;
        cycle();
        redir_pc = 32'h400;
        #1;
        check("collide_fetch_valid", 32'(dec_if.fetch_valid_o), 32'd0);
        cycle();
        redir = 1'b0;
        check("collide_pc", cpc[0], 32'h400);

        // Address-space wrap.
        redir = 1'b1;
        redir_pc = 32'hFFFF_FFEC;
        cycle();
        redir = 1'b0;
        #1;
        check("wrap_pc4", cpc[4], 32'hFFFF_FFFC);
        cycle();
        check("wrap_next_pc", cpc[0], 32'h0);

        // Asynchronous reset while parked.
        put_jalr(0);
        jp_valid = 1'b0;
        cycle();
        clear_ctl();
        imem = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        m_pc = RESET_PC;
        m_parked = 0;
        check("async_rst_pc",    cpc[0], RESET_PC);
        check("async_rst_valid", 32'(dec_if.fetch_valid_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        imem = 1'b1;
        #1;
        check("post_rst_valid", 32'(dec_if.fetch_valid_o), 32'd1);
        cycle();

        // Randomized groups.
        for (int n = 0; n < 3000; n++) begin
            clear_ctl();
            imem = ($urandom_range(7, 0) != 0);
            dec_if.fetch_ready_i = ($urandom_range(3, 0) != 0);
            redir = ($urandom_range(15, 0) == 0);
            redir_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(63, 0)))
                                                   : $urandom;
            jp_valid = $urandom_range(1, 0) != 0;
            jp_target = $urandom;
            for (int s = 0; s < 5; s++) begin
                logic [20:0] ji;
                logic [12:0] bi;
                int          r;
                r  = $urandom_range(9, 0);
                ji = 21'($urandom);
                bi = 13'($urandom);
                ji[0] = 1'b0;
                bi[0] = 1'b0;
                if (r == 0)      put_jal(s, ji);
                else if (r == 1) put_br(s, bi);
                else if (r == 2) put_jalr(s);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
